bitsplit_ctrl: RTL and testbench

Sequencer and two-port arbiter for the byte bit-splitter datapath. It accepts bytes from two requesters over valid/ready handshakes, grants one at a time, and drives the load/shift sequence of the internal PISO, toggle-phase and dual-SIPO path. It then presents the assembled even and odd nibbles on a valid/ready output port. It sits between upstream byte producers and any consumer of split nibble pairs.

---
 rtl/bitsplit_ctrl.sv | 178 +++++++++++++++++
 tb/tb_bitsplit_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bitsplit_ctrl.sv
// bitsplit_ctrl: two-port arbiter and sequencer for the byte bit-splitter path.
// It accepts a byte from one of two valid/ready requesters and loads it into a
// PISO. The byte is shifted out LSB first over 8 cycles. Even-slot bits go to
// the even SIPO and odd-slot bits go to the odd SIPO. The two nibbles are then
// presented on a valid/ready output port.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req0_valid/req0_data/req0_ready requester 0 byte handshake
//   req1_valid/req1_data/req1_ready requester 1 byte handshake
//   ld                              one-cycle load strobe per byte
//   ser_even, ser_odd               serial even/odd bit during SHIFT, else 0
//   out_valid/out_ready             nibble-pair handshake
//   out_even, out_odd, out_src      {d6,d4,d2,d0}, {d7,d5,d3,d1}, source index
//   busy                            high whenever not IDLE
//
// Build option:
//   BITSPLIT_CTRL_RR_EN  round-robin arbitration (default: fixed priority, req0 wins)
module bitsplit_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       ld,
  output logic       ser_even,
  output logic       ser_odd,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_even,
  output logic [3:0] out_odd,
  output logic       out_src,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_data;
  logic [7:0] r_piso;
  logic [3:0] r_even;
  logic [3:0] r_odd;
  logic [2:0] r_cnt;
  logic       r_phase;
  logic       r_src;
  logic       w_accept;
  logic       w_gnt_sel;

  // A grant only happens in IDLE, and never while reset is asserted.
  assign w_accept = (r_state == S_IDLE) && (req0_valid || req1_valid) && !rst;

`ifdef BITSPLIT_CTRL_RR_EN
  logic r_last;

  // On contention, grant the requester not granted last.
  always_comb begin
    w_gnt_sel = !req0_valid;
    if (req0_valid && req1_valid) begin
      w_gnt_sel = !r_last;
    end
  end

  // r_last resets to 1 so that requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_gnt_sel;
    end
  end
`else
  // Fixed priority: requester 1 is granted only when requester 0 is idle.
  assign w_gnt_sel = !req0_valid;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_piso  <= '0;
      r_even  <= '0;
      r_odd   <= '0;
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_src   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_data <= w_gnt_sel ? req1_data : req0_data;
            r_src  <= w_gnt_sel;
          end
        end
        S_LOAD: begin
          r_piso  <= r_data;
          r_phase <= 1'b0;
          r_cnt   <= '0;
          r_even  <= '0;
          r_odd   <= '0;
        end
        S_SHIFT: begin
          r_piso <= {1'b0, r_piso[7:1]};
          // Each SIPO shifts right with the new bit at the MSB.
          // After 4 shifts its first bit sits in bit 0.
          if (!r_phase) begin
            r_even <= {r_piso[0], r_even[3:1]};
          end else begin
            r_odd  <= {r_piso[0], r_odd[3:1]};
          end
          r_phase <= !r_phase;
          r_cnt   <= r_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    ld         = 1'b0;
    ser_even   = 1'b0;
    ser_odd    = 1'b0;
    out_valid  = 1'b0;
    out_even   = '0;
    out_odd    = '0;
    out_src    = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          req0_ready = !w_gnt_sel;
          req1_ready = w_gnt_sel;
          w_next     = S_LOAD;
        end
      end
      S_LOAD: begin
        ld     = 1'b1;
        w_next = S_SHIFT;
      end
      S_SHIFT: begin
        ser_even = !r_phase && r_piso[0];
        ser_odd  = r_phase && r_piso[0];
        if (r_cnt == 3'd7) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        out_even  = r_even;
        out_odd   = r_odd;
        out_src   = r_src;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bitsplit_ctrl.sv
module tb_bitsplit_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       ld, ser_even, ser_odd;
  logic       out_valid, out_ready;
  logic [3:0] out_even, out_odd;
  logic       out_src, busy;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int low_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bitsplit_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .ld         (ld),
    .ser_even   (ser_even),
    .ser_odd    (ser_odd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_even   (out_even),
    .out_odd    (out_odd),
    .out_src    (out_src),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just past the edge. Count cycles with busy low.
  task automatic step();
    @(posedge clk);
    #1;
    if (!busy) low_cnt++;
  endtask

  // Wait for a grant, with a bounded wait. who = 0/1 on a grant, -1 on timeout.
  task automatic wait_ready(output int who);
    int k;
    k = 0;
    #1;
    while (!(req0_ready || req1_ready) && k < 30) begin
      step();
      k++;
    end
    if (req0_ready || req1_ready) begin
      check("one_ready", {31'd0, req0_ready & req1_ready}, 0);
      who = req1_ready ? 1 : 0;
    end else begin
      check("ready_timeout", 0, 1);
      who = -1;
    end
  endtask

  task automatic pair(input string tag, input logic [3:0] e, input logic [3:0] o, input logic s);
    check({tag, "_valid"}, {31'd0, out_valid}, 1);
    check({tag, "_even"}, {28'd0, out_even}, {28'd0, e});
    check({tag, "_odd"}, {28'd0, out_odd}, {28'd0, o});
    check({tag, "_src"}, {31'd0, out_src}, {31'd0, s});
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_ld"}, {31'd0, ld}, 0);
    check({tag, "_ser"}, {30'd0, ser_even, ser_odd}, 0);
    check({tag, "_ovalid"}, {31'd0, out_valid}, 0);
    check({tag, "_data"}, {23'd0, out_src, out_even, out_odd}, 0);
    check({tag, "_rdy"}, {30'd0, req0_ready, req1_ready}, 0);
  endtask

  initial begin
    int who, exp_g, t, tprev, seen;
    logic [7:0] ev, od;
    logic [7:0] d5 [4];
    logic [3:0] e5 [4];
    logic [3:0] o5 [4];

    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0; out_ready = 1'b0;
    step();
    // Reset overrides a pending request.
    req0_valid = 1'b1;
    step();
    all_zero("reset");
    req0_valid = 1'b0;
    rst = 1'b0;

    // Single byte B4: even bits 0,1,1,0 then odd bits 0,0,1,1. Pair is 6/C.
    req0_data = 8'hB4; req0_valid = 1'b1; out_ready = 1'b1;
    wait_ready(who);
    check("t1_grant", who, 0);
    check("t1_busy_T", {31'd0, busy}, 0);
    step();
    req0_valid = 1'b0;
    check("t1_ld", {31'd0, ld}, 1);
    check("t1_busy_ld", {31'd0, busy}, 1);
    ev = 8'h14;
    od = 8'hA0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t1_ser_even", {31'd0, ser_even}, {31'd0, ev[i]});
      check("t1_ser_odd", {31'd0, ser_odd}, {31'd0, od[i]});
      check("t1_ld_low", {31'd0, ld}, 0);
    end
    step();
    pair("t1", 4'h6, 4'hC, 1'b0);
    step();
    check("t1_idle", {31'd0, busy}, 0);
    check("t1_ovalid_low", {31'd0, out_valid}, 0);

    // Backpressure with FF from requester 1.
    req1_data = 8'hFF; req1_valid = 1'b1; out_ready = 1'b0;
    wait_ready(who);
    check("t2_grant", who, 1);
    step();
    req1_valid = 1'b0;
    repeat (9) step();
    for (int i = 0; i < 5; i++) begin
      pair("t2_hold", 4'hF, 4'hF, 1'b1);
      check("t2_rdy", {30'd0, req0_ready, req1_ready}, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    pair("t2_hs", 4'hF, 4'hF, 1'b1);
    step();
    check("t2_idle", {31'd0, busy}, 0);

    // Contention: 0F on port 0 gives 3/3, F0 on port 1 gives C/C.
    req0_data = 8'h0F; req1_data = 8'hF0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_ready(who);
`ifdef BITSPLIT_CTRL_RR_EN
      exp_g = g % 2;
`else
      exp_g = 0;
`endif
      check("t3_grant", who, exp_g);
      repeat (10) step();
      check("t3_rdy_done", {30'd0, req0_ready, req1_ready}, 0);
      if (exp_g == 1) pair("t3", 4'hC, 4'hC, 1'b1);
      else            pair("t3", 4'h3, 4'h3, 1'b0);
      if (g == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      step();
    end

    // Reset during SHIFT drops the byte. A fresh 55 then gives F/0.
    req0_data = 8'hA5; req0_valid = 1'b1;
    wait_ready(who);
    check("t4_grant", who, 0);
    step();
    req0_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    all_zero("t4_rst");
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      step();
      if (out_valid) seen = 1;
    end
    check("t4_no_pair", seen, 0);
    req0_data = 8'h55; req0_valid = 1'b1;
    wait_ready(who);
    check("t4b_grant", who, 0);
    step();
    req0_valid = 1'b0;
    repeat (9) step();
    pair("t4b", 4'hF, 4'h0, 1'b0);
    step();

    // Back-to-back bytes on port 0 with out_ready held high.
    d5[0] = 8'hB4; e5[0] = 4'h6; o5[0] = 4'hC;
    d5[1] = 8'h55; e5[1] = 4'hF; o5[1] = 4'h0;
    d5[2] = 8'hFF; e5[2] = 4'hF; o5[2] = 4'hF;
    d5[3] = 8'h0F; e5[3] = 4'h3; o5[3] = 4'h3;
    req0_data = d5[0]; req0_valid = 1'b1; out_ready = 1'b1;
    tprev = 0;
    for (int b = 0; b < 4; b++) begin
      wait_ready(who);
      check("t5_grant", who, 0);
      t = cyc;
      if (b > 0) begin
        check("t5_gap", t - tprev, 11);
        check("t5_busy_low", low_cnt, 1);
      end
      low_cnt = 0;
      tprev = t;
      step();
      if (b < 3) req0_data = d5[b+1];
      else       req0_valid = 1'b0;
      repeat (9) step();
      pair("t5", e5[b], o5[b], 1'b0);
    end
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
